mmio_timer: RTL and testbench

- Memory-mapped 32-bit down-counting timer peripheral on the SoC IO page (word base 0x00100010, byte 0x00400040).
- Four word registers: CTRL, LOAD, VALUE, STATUS. Selected via `sel` and a 2-bit word offset.
- Supports one-shot and periodic modes.
- Drives a sticky `timeout_o` level that the SoC edge-detects, for example to toggle LED0.

---
 rtl/mmio_timer.sv | 188 ++++++++++++++++++
 tb/tb_mmio_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit down-counting timer with one-shot/periodic modes and a sticky timeout flag.
// Optional prescaler is compiled in when TIMER_PRESCALER_EN is defined.
module mmio_timer #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timeout_o
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_VALUE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             en_reg,    en_next;
  logic             mode_reg,  mode_next;
  logic [CNT_W-1:0] load_reg,  load_next;
  logic [CNT_W-1:0] value_reg, value_next;
  logic             to_reg,    to_next;
  logic [31:0]      rdata_reg, rdata_next;

  logic wr_hit, rd_hit;
  logic wr_ctrl, wr_load, wr_status;
  logic start;
  logic tick;
  logic value_zero;

  assign wr_hit    = sel & wr_en;
  assign rd_hit    = sel & rd_en;
  assign wr_ctrl   = wr_hit && (addr == ADDR_CTRL);
  assign wr_load   = wr_hit && (addr == ADDR_LOAD);
  assign wr_status = wr_hit && (addr == ADDR_STATUS);
  // VALUE is read-only, so a write decoded to it has no effect anywhere.

  assign start      = wr_ctrl && wdata[0] && !en_reg;
  assign value_zero = (value_reg == '0);

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_reg,     presc_next;
  logic [PRESC_W-1:0] presc_cnt_reg, presc_cnt_next;

  assign tick = en_reg && (presc_cnt_reg == presc_reg);

  always_comb begin
    presc_next     = presc_reg;
    presc_cnt_next = presc_cnt_reg;
    if (en_reg) begin
      presc_cnt_next = tick ? '0 : presc_cnt_reg + PRESC_W'(1);
    end
    if (start) begin
      presc_cnt_next = '0;
    end
    if (wr_ctrl) begin
      presc_next = wdata[8 +: PRESC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
    end else begin
      presc_reg     <= presc_next;
      presc_cnt_reg <= presc_cnt_next;
    end
  end
`else
  localparam int unused_presc_w = PRESC_W;

  assign tick = en_reg;
`endif

  // Counter, control and status next-state; later assignments take priority.
  always_comb begin
    en_next    = en_reg;
    mode_next  = mode_reg;
    load_next  = load_reg;
    value_next = value_reg;
    to_next    = to_reg;

    if (tick) begin
      if (!value_zero) begin
        value_next = value_reg - CNT_ONE;
      end else if (mode_reg) begin
        value_next = load_reg;
      end else begin
        en_next = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_next    = wdata[0];
      mode_next  = wdata[1];
      value_next = start ? load_reg : value_reg;
    end

    if (wr_load) begin
      load_next = wdata[CNT_W-1:0];
    end

    if (wr_status && wdata[0]) begin
      to_next = 1'b0;
    end
    if (tick && value_zero) begin
      to_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg    <= 1'b0;
      mode_reg  <= 1'b0;
      load_reg  <= '0;
      value_reg <= '0;
      to_reg    <= 1'b0;
    end else begin
      en_reg    <= en_next;
      mode_reg  <= mode_next;
      load_reg  <= load_next;
      value_reg <= value_next;
      to_reg    <= to_next;
    end
  end

  // Zero-extend the counter registers onto the 32-bit read bus.
  logic [31:0] load_ext;
  logic [31:0] value_ext;

  for (genvar gi = 0; gi < 32; gi++) begin : g_ext
    if (gi < CNT_W) begin : g_bit
      assign load_ext[gi]  = load_reg[gi];
      assign value_ext[gi] = value_reg[gi];
    end else begin : g_pad
      assign load_ext[gi]  = 1'b0;
      assign value_ext[gi] = 1'b0;
    end
  end

  logic [31:0] ctrl_rd;

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en_reg;
    ctrl_rd[1] = mode_reg;
`ifdef TIMER_PRESCALER_EN
    ctrl_rd[8 +: PRESC_W] = presc_reg;
`endif
  end

  always_comb begin
    rdata_next = rdata_reg;
    if (rd_hit) begin
      unique case (addr)
        ADDR_CTRL:   rdata_next = ctrl_rd;
        ADDR_LOAD:   rdata_next = load_ext;
        ADDR_VALUE:  rdata_next = value_ext;
        ADDR_STATUS: rdata_next = {31'd0, to_reg};
        default:     rdata_next = rdata_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  // Only a handful of write-data bits are decoded for any given build.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign rdata     = rdata_reg;
  assign timeout_o = to_reg;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: reset, one-shot, periodic, prescaler,
// same-cycle collisions and bus gating. Expectations follow TIMER_PRESCALER_EN when defined.
module tb_mmio_timer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_VALUE  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

`ifdef TIMER_PRESCALER_EN
  localparam int          PRESC_TO_CYC = 15;
  localparam logic [31:0] PRESC_CTRL   = 32'h0000_0403;
`else
  localparam int          PRESC_TO_CYC = 3;
  localparam logic [31:0] PRESC_CTRL   = 32'h0000_0003;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sel   = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  mmio_timer dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered just after a falling edge and return just after the next one.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr_en = 1'b0;
    $display("WR addr=%0d data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rd_en = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rd_en = 1'b0;
    d = rdata;
    $display("RD addr=%0d data=0x%08h", a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_to", {31'd0, timeout_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      check("rst_reg", rd, 32'd0);
    end

    // One-shot: LOAD=5, VALUE counts 5..0, timeout on the 6th tick
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'h1);
    sel = 1'b1; rd_en = 1'b1; addr = A_VALUE;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("os_value", rdata, 32'(6 - k));
      check("os_to", {31'd0, timeout_o}, {31'd0, (k == 6)});
    end
    sel = 1'b0; rd_en = 1'b0;
    $display("RD addr=2 burst of 6 reads");
    bus_read(A_CTRL, rd);
    check("os_ctrl", rd, 32'h0);
    bus_read(A_VALUE, rd);
    check("os_value_hold", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("os_status", rd, 32'h1);
    bus_write(A_STATUS, 32'h1);
    check("os_w1c", {31'd0, timeout_o}, 32'd0);

    // Periodic: LOAD=3, VALUE 3,2,1,0,3 and timeout 4 cycles after start
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'h3);
    sel = 1'b1; rd_en = 1'b1; addr = A_VALUE;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("per_value", rdata, (k == 5) ? 32'd3 : 32'(4 - k));
      check("per_to", {31'd0, timeout_o}, {31'd0, (k >= 4)});
    end
    sel = 1'b0; rd_en = 1'b0;
    $display("RD addr=2 burst of 5 reads");
    bus_write(A_STATUS, 32'h1);
    check("per_clr", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    check("per_clr_hold", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    check("per_reset_again", {31'd0, timeout_o}, 32'd1);

    // W1C on the exact timeout cycle: set wins
    repeat (3) @(negedge clk);
    bus_write(A_STATUS, 32'h1);
    check("w1c_coll", {31'd0, timeout_o}, 32'd1);
    bus_write(A_STATUS, 32'h1);
    check("w1c_after", {31'd0, timeout_o}, 32'd0);

    // CTRL=0 on a tick cycle: VALUE keeps its pre-tick value of 2
    bus_write(A_CTRL, 32'h0);
    bus_read(A_VALUE, rd);
    check("ctrl_coll_value", rd, 32'd2);
    repeat (3) @(negedge clk);
    bus_read(A_VALUE, rd);
    check("stop_value_hold", rd, 32'd2);
    check("stop_to", {31'd0, timeout_o}, 32'd0);

    // Prescaler: LOAD=2, CTRL=0x0403
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h0403);
    bus_read(A_CTRL, rd);
    check("presc_ctrl", rd, PRESC_CTRL);
    repeat (PRESC_TO_CYC - 2) @(negedge clk);
    check("presc_to_early", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    check("presc_to", {31'd0, timeout_o}, 32'd1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    check("presc_clr", {31'd0, timeout_o}, 32'd0);

    // Bus gating: start with LOAD=9 then stop on the next (tick) cycle
    bus_write(A_LOAD, 32'd9);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_VALUE, 32'h55);
    bus_read(A_VALUE, rd);
    check("value_ro", rd, 32'd9);
    sel = 1'b0; wr_en = 1'b1; addr = A_LOAD; wdata = 32'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    $display("WR addr=1 data=0x000000aa with sel=0");
    bus_read(A_LOAD, rd);
    check("load_nosel", rd, 32'd9);
    sel = 1'b0; rd_en = 1'b1; addr = A_CTRL;
    @(negedge clk);
    rd_en = 1'b0;
    $display("RD addr=0 with sel=0");
    check("rdata_hold_nosel", rdata, 32'd9);
    sel = 1'b1; rd_en = 1'b0; addr = A_CTRL;
    @(negedge clk);
    sel = 1'b0;
    $display("sel=1 with no strobe");
    check("rdata_hold_nord", rdata, 32'd9);
    bus_read(A_CTRL, rd);
    check("rdata_update", rd, 32'h0);

    // Asynchronous reset in the middle of a periodic run
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    bus_read(A_LOAD, rd);
    check("pre_rst_to", {31'd0, timeout_o}, 32'd1);
    check("pre_rst_rdata", rd, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_to", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), rd);
      check("post_rst_reg", rd, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
